// File: rtl/zap_predecode_mem_fsm_pkg.sv
// zap_predecode_mem_fsm_pkg: shared state type, ARM encodings and micro-op builders for LDM/STM expansion.
package zap_predecode_mem_fsm_pkg;
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [2:0] LDM_STM = 3'b100;
   localparam logic [2:0] MEM_IMM = 3'b010;
   localparam logic [2:0] DP_IMM  = 3'b001;
   localparam logic [3:0] OPC_ADD = 4'b0100;
   localparam logic [3:0] OPC_SUB = 4'b0010;
   localparam logic [3:0] REG_PC  = 4'd15;
   localparam logic [15:0] ONLY_PC = 16'h8000;
   function automatic logic [31:0] mem_uop(input logic [3:0] cond, input logic u, l,
                                           input logic [3:0] rn, rd, input logic [11:0] imm);
      return {cond, MEM_IMM, 1'b1, u, 2'b00, l, rn, rd, imm};
   endfunction
   function automatic logic [31:0] wb_uop(input logic [3:0] cond, input logic u,
                                          input logic [3:0] rn, input logic [7:0] imm);
      return {cond, DP_IMM, u ? OPC_ADD : OPC_SUB, 1'b0, rn, rn, 4'h0, imm};
   endfunction
endpackage

// File: rtl/zap_predecode_mem_fsm_if.sv
// zap_predecode_mem_fsm_if: instruction, pipeline control and interrupt signals around the predecode stage.
interface zap_predecode_mem_fsm_if;
   logic        i_clear_from_writeback;
   logic        i_data_stall;
   logic        i_clear_from_alu;
   logic        i_stall_from_shifter;
   logic        i_stall_from_issue;
   logic [34:0] i_instruction;
   logic        i_instruction_valid;
   logic        i_irq;
   logic        i_fiq;
   logic [34:0] o_instruction;
   logic        o_instruction_valid;
   logic        o_stall_from_decode;
   logic        o_irq;
   logic        o_fiq;
   modport master (
      output i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter,
             i_stall_from_issue, i_instruction, i_instruction_valid, i_irq, i_fiq,
      input  o_instruction, o_instruction_valid, o_stall_from_decode, o_irq, o_fiq
   );
   modport slave (
      input  i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter,
             i_stall_from_issue, i_instruction, i_instruction_valid, i_irq, i_fiq,
      output o_instruction, o_instruction_valid, o_stall_from_decode, o_irq, o_fiq
   );
endinterface

// File: rtl/zap_predecode_lowbit_sel.sv
// zap_predecode_lowbit_sel: lowest set index of a register mask, the mask without it, and its popcount.
module zap_predecode_lowbit_sel (
   input  logic [15:0] mask_i,
   output logic [3:0]  idx_o,
   output logic [15:0] rest_o,
   output logic [4:0]  cnt_o
);
   always_comb begin
      idx_o = '0;
      cnt_o = '0;
      for (int i = 15; i >= 0; i--) begin
         if (mask_i[i]) idx_o = 4'(i);
         cnt_o = cnt_o + 5'(mask_i[i]);
      end
   end
   assign rest_o = mask_i & (mask_i - 16'd1);
endmodule

// File: rtl/zap_predecode_mem_fsm.sv
// zap_predecode_mem_fsm: expands LDM/STM into single LDR/STR micro-ops plus base writeback; others pass through.
module zap_predecode_mem_fsm
   import zap_predecode_mem_fsm_pkg::*;
(
   input logic                     i_clk,
   input logic                     i_reset,
   zap_predecode_mem_fsm_if.slave  bus
);
   state_t      state_q, state_d;
   logic [15:0] mask_q, mask_d;
   logic [4:0]  k_q, k_d;
   logic        wb_q, wb_d;
   logic [31:0] ins_q, ins_d;
   logic        busy, active, wb_en, cur_wb, early, do_wb, pc_delta, last, clr, hold, adv;
   logic [31:0] cur_ins, uop;
   logic [15:0] cur_mask, rest, nxt_mask;
   logic [4:0]  cur_k, cnt, n, nxt_k;
   logic [3:0]  idx, rn;
   logic [6:0]  w, mag;
   logic        nxt_wb;

   zap_predecode_lowbit_sel u_sel (.mask_i(cur_mask), .idx_o(idx), .rest_o(rest), .cnt_o(cnt));

   // In IDLE the first micro-op is built straight from the live input word (zero latency).
   always_comb begin
      busy     = state_q == BUSY;
      cur_ins  = busy ? ins_q : bus.i_instruction[31:0];
      rn       = cur_ins[19:16];
      active   = busy || (bus.i_instruction_valid && cur_ins[27:25] == LDM_STM && !cur_ins[22] && |cur_ins[15:0]);
      cur_mask = busy ? mask_q : cur_ins[15:0];
      cur_k    = busy ? k_q : 5'd0;
      wb_en    = cur_ins[21] & ~(cur_ins[20] & cur_ins[rn]);
      cur_wb   = busy ? wb_q : wb_en;
      n        = cur_k + cnt;
      early    = cur_ins[20] & cur_wb & (cur_mask == ONLY_PC);
      do_wb    = early | (cur_mask == 16'd0);
      pc_delta = cur_ins[20] & wb_en & (idx == REG_PC);
      // Word offset; a PC load after an early writeback is rebased onto the updated Rn.
      w        = 7'(cur_k) + 7'(cur_ins[24] == cur_ins[23]) - ((cur_ins[23] == pc_delta) ? 7'(n) : 7'd0);
      mag      = w[6] ? 7'(-w) : w;
      uop      = do_wb ? wb_uop(cur_ins[31:28], cur_ins[23], rn, {1'b0, n, 2'b00})
                       : mem_uop(cur_ins[31:28], ~w[6], cur_ins[20], rn, idx, {3'b000, mag, 2'b00});
      nxt_mask = do_wb ? cur_mask : rest;
      nxt_k    = do_wb ? cur_k : cur_k + 5'd1;
      nxt_wb   = cur_wb & ~do_wb;
      last     = (nxt_mask == 16'd0) & ~nxt_wb;
      clr      = bus.i_clear_from_writeback | (~bus.i_data_stall & bus.i_clear_from_alu);
      hold     = bus.i_data_stall | bus.i_stall_from_shifter | bus.i_stall_from_issue;
      adv      = ~clr & ~hold & active;
      state_d  = clr ? IDLE : hold ? state_q : (active && !last) ? BUSY : IDLE;
      mask_d   = adv ? nxt_mask : mask_q;
      k_d      = adv ? nxt_k : k_q;
      wb_d     = adv ? nxt_wb : wb_q;
      ins_d    = adv ? cur_ins : ins_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         k_q     <= '0;
         wb_q    <= 1'b0;
         ins_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         k_q     <= k_d;
         wb_q    <= wb_d;
         ins_q   <= ins_d;
      end
   end

   assign bus.o_instruction       = active ? {bus.i_instruction[34:32], uop} : bus.i_instruction;
   assign bus.o_instruction_valid = bus.i_instruction_valid;
   assign bus.o_stall_from_decode = active & ~last;
   assign bus.o_irq               = busy ? 1'b0 : bus.i_irq;
   assign bus.o_fiq               = busy ? 1'b0 : bus.i_fiq;
endmodule
